// File: rtl/my_clkdiv_pkg.sv
// Shared types and helpers for the my_clkdiv_multi clock generator.
package my_clkdiv_pkg;

    typedef enum logic [1:0] {
        LOCKING = 2'd0,
        LOCKED  = 2'd1,
        RECONF  = 2'd2
    } clkdiv_state_e;

    localparam int CH_IDX_W = 3;

    // A request is legal when it targets an existing channel and divides by at least 2.
    function automatic logic cfg_is_legal(input logic [CH_IDX_W-1:0] ch,
                                          input logic [63:0]         div,
                                          input int                  num_ch);
        return (int'(ch) < num_ch) && (div >= 64'd2);
    endfunction

endpackage

// File: rtl/my_clkdiv_chan.sv
// One divided-clock channel: divisor register, wrap counter, registered outclk and tick.
module my_clkdiv_chan #(
    parameter int CNT_W       = 24,
    parameter int DIV_DEFAULT = 50
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             restart,
    input  logic             load,
    input  logic [CNT_W-1:0] div,
    output logic             outclk,
    output logic             tick
);

    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] half;
    logic             wrap;
    logic             armed_q;

    assign cnt_inc = cnt_q + 1'b1;
    assign half    = div_q >> 1;
    assign wrap    = (cnt_q == div_q - 1'b1);

    // armed_q keeps outclk low until the first full period after a restart,
    // so the first rising edge lines up with the first tick.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= CNT_W'(DIV_DEFAULT);
            cnt_q   <= '0;
            armed_q <= 1'b0;
            outclk  <= 1'b0;
            tick    <= 1'b0;
        end else begin
            if (load) begin
                div_q <= div;
            end
            if (restart) begin
                cnt_q   <= '0;
                armed_q <= 1'b0;
                outclk  <= 1'b0;
                tick    <= 1'b0;
            end else if (wrap) begin
                cnt_q   <= '0;
                armed_q <= 1'b1;
                outclk  <= 1'b1;
                tick    <= 1'b1;
            end else begin
                cnt_q   <= cnt_inc;
                outclk  <= armed_q && (cnt_inc < half);
                tick    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/my_clkdiv_multi.sv
// Multi-channel programmable clock divider with lock indicator and cfg handshake.
// Optional MY_CLKDIV_PHASE_ALIGN_EN: every reconfiguration restarts all channels together.
module my_clkdiv_multi
    import my_clkdiv_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 24,
    parameter int DIV_DEFAULT = 50,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                refclk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_IDX_W-1:0] cfg_ch,
    input  logic [CNT_W-1:0]    cfg_div,
    output logic                cfg_err,
    output logic [NUM_CH-1:0]   outclk,
    output logic [NUM_CH-1:0]   outclk_tick,
    output logic                locked
);

    localparam int               LCK_W     = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LCK_W-1:0] LOCK_LAST = LCK_W'(LOCK_CYCLES - 1);

    clkdiv_state_e       state_q, state_d;
    logic [LCK_W-1:0]    lock_cnt_q, lock_cnt_d;
    logic [CH_IDX_W-1:0] cap_ch_q;
    logic [CNT_W-1:0]    cap_div_q;
    logic                take_ok;
    logic                cfg_err_d;
    logic [NUM_CH-1:0]   ch_restart;
    logic [NUM_CH-1:0]   ch_load;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOCKING;
            lock_cnt_q <= '0;
            cfg_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            cfg_err    <= cfg_err_d;
        end
    end

    // Captured request is only consumed in RECONF, which reset always leaves.
    always_ff @(posedge refclk) begin
        if (take_ok) begin
            cap_ch_q  <= cfg_ch;
            cap_div_q <= cfg_div;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        cfg_ready  = 1'b0;
        locked     = 1'b0;
        take_ok    = 1'b0;
        cfg_err_d  = 1'b0;
        case (state_q)
            LOCKING: begin
                if (lock_cnt_q == LOCK_LAST) begin
                    state_d    = LOCKED;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            LOCKED: begin
                locked    = 1'b1;
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    if (cfg_is_legal(cfg_ch, 64'(cfg_div), NUM_CH)) begin
                        take_ok = 1'b1;
                        state_d = RECONF;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            RECONF: begin
                state_d    = LOCKING;
                lock_cnt_d = '0;
            end
            default: begin
                state_d    = LOCKING;
                lock_cnt_d = '0;
            end
        endcase
    end

    // Restart on acceptance clears the outputs during RECONF; restart in RECONF
    // holds the counter at 0 while the new divisor is written.
    always_comb begin
        ch_restart = '0;
        ch_load    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_load[i] = (state_q == RECONF) && (cap_ch_q == CH_IDX_W'(i));
`ifdef MY_CLKDIV_PHASE_ALIGN_EN
            ch_restart[i] = take_ok || (state_q == RECONF);
`else
            ch_restart[i] = (take_ok && (cfg_ch == CH_IDX_W'(i))) || ch_load[i];
`endif
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        my_clkdiv_chan #(
            .CNT_W       (CNT_W),
            .DIV_DEFAULT (DIV_DEFAULT)
        ) u_chan (
            .refclk  (refclk),
            .rst_n   (rst_n),
            .restart (ch_restart[g]),
            .load    (ch_load[g]),
            .div     (cap_div_q),
            .outclk  (outclk[g]),
            .tick    (outclk_tick[g])
        );
    end

endmodule

// File: tb/tb_my_clkdiv_multi.sv
// Directed bench for my_clkdiv_multi; honours MY_CLKDIV_PHASE_ALIGN_EN when defined.
module tb_my_clkdiv_multi;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 24;
`ifdef MY_CLKDIV_PHASE_ALIGN_EN
    localparam int PA = 18;
`else
    localparam int PA = 0;
`endif

    logic              refclk = 1'b0;
    logic              rst_n;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [2:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_err;
    logic [NUM_CH-1:0] outclk;
    logic [NUM_CH-1:0] outclk_tick;
    logic              locked;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    my_clkdiv_multi #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DIV_DEFAULT (50),
        .LOCK_CYCLES (16)
    ) dut (
        .refclk      (refclk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .cfg_err     (cfg_err),
        .outclk      (outclk),
        .outclk_tick (outclk_tick),
        .locked      (locked)
    );

    always #5 refclk = ~refclk;

    // Edges since the latest reset release.
    always @(posedge refclk) cyc <= rst_n ? cyc + 1 : 0;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic at_edge(input int e);
        while (cyc < e) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic send(input logic [2:0] ch, input logic [CNT_W-1:0] div);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = div;
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        repeat (3) @(posedge refclk);
        #1;
        check("rst_outclk", 32'(outclk), 32'h0);
        check("rst_tick",   32'(outclk_tick), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_ready",  32'(cfg_ready), 32'h0);
        check("rst_err",    32'(cfg_err), 32'h0);
        @(negedge refclk);
        rst_n = 1'b1;

        // Default divisor 50 on every channel, lock after 16 cycles
        at_edge(15);  check("lock_c15", 32'(locked), 32'h0);
        at_edge(16);  check("lock_c16", 32'(locked), 32'h1);
        check("ready_c16", 32'(cfg_ready), 32'h1);
        check("outclk_c16", 32'(outclk), 32'h0);
        at_edge(49);  check("tick_c49", 32'(outclk_tick), 32'h0);
        check("outclk_c49", 32'(outclk), 32'h0);
        at_edge(50);  check("tick_c50", 32'(outclk_tick), 32'hF);
        check("outclk_c50", 32'(outclk), 32'hF);
        at_edge(51);  check("tick_c51", 32'(outclk_tick), 32'h0);
        check("outclk_c51", 32'(outclk), 32'hF);
        at_edge(74);  check("outclk_c74", 32'(outclk), 32'hF);
        at_edge(75);  check("outclk_c75", 32'(outclk), 32'h0);
        at_edge(100); check("tick_c100", 32'(outclk_tick), 32'hF);

        // Illegal requests: divisor 1, then channel 5
        send(3'd0, 24'd1);
        at_edge(101);
        cfg_valid = 1'b0;
        check("err_div1", 32'(cfg_err), 32'h1);
        check("lock_div1", 32'(locked), 32'h1);
        check("ready_div1", 32'(cfg_ready), 32'h1);
        at_edge(102); check("err_clr1", 32'(cfg_err), 32'h0);
        send(3'd5, 24'd3);
        at_edge(103);
        cfg_valid = 1'b0;
        check("err_ch5", 32'(cfg_err), 32'h1);
        check("lock_ch5", 32'(locked), 32'h1);
        at_edge(104); check("err_clr2", 32'(cfg_err), 32'h0);
        at_edge(150); check("tick_c150", 32'(outclk_tick), 32'hF);
        check("outclk_c150", 32'(outclk), 32'hF);

        // Reprogram ch1 to divide by 3
        send(3'd1, 24'd3);
        at_edge(151);
        cfg_valid = 1'b0;
        check("ready_acc", 32'(cfg_ready), 32'h0);
        check("lock_acc", 32'(locked), 32'h0);
`ifdef MY_CLKDIV_PHASE_ALIGN_EN
        check("outclk_reconf", 32'(outclk), 32'h0);
`else
        check("outclk_reconf", 32'(outclk), 32'hD);
`endif
        check("tick_reconf", 32'(outclk_tick), 32'h0);
        at_edge(152); check("ch1_clk_152", 32'(outclk[1]), 32'h0);
        check("lock_152", 32'(locked), 32'h0);
        at_edge(154); check("ch1_tick_154", 32'(outclk_tick[1]), 32'h0);
        check("ch1_clk_154", 32'(outclk[1]), 32'h0);
        at_edge(155); check("ch1_tick_155", 32'(outclk_tick[1]), 32'h1);
        check("ch1_clk_155", 32'(outclk[1]), 32'h1);
        at_edge(156); check("ch1_tick_156", 32'(outclk_tick[1]), 32'h0);
        check("ch1_clk_156", 32'(outclk[1]), 32'h0);
        at_edge(157); check("ch1_clk_157", 32'(outclk[1]), 32'h0);
        at_edge(158); check("ch1_tick_158", 32'(outclk_tick[1]), 32'h1);
        check("ch1_clk_158", 32'(outclk[1]), 32'h1);
        at_edge(167); check("lock_167", 32'(locked), 32'h0);
        at_edge(168); check("lock_168", 32'(locked), 32'h1);
        check("ready_168", 32'(cfg_ready), 32'h1);
`ifdef MY_CLKDIV_PHASE_ALIGN_EN
        at_edge(201); check("ch0_tick_201", 32'(outclk_tick[0]), 32'h0);
        at_edge(202); check("ch0_tick_202", 32'(outclk_tick[0]), 32'h1);
`else
        at_edge(174); check("others_clk_174", 32'(outclk & 4'hD), 32'hD);
        at_edge(175); check("others_clk_175", 32'(outclk & 4'hD), 32'h0);
        at_edge(200); check("others_tick_200", 32'(outclk_tick & 4'hD), 32'hD);
`endif

        // Reset asserted while in RECONF
        at_edge(205);
        send(3'd2, 24'd7);
        at_edge(206);
        check("ready_pre_rst", 32'(cfg_ready), 32'h0);
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        #1;
        check("mid_rst_outclk", 32'(outclk), 32'h0);
        check("mid_rst_tick",   32'(outclk_tick), 32'h0);
        check("mid_rst_locked", 32'(locked), 32'h0);
        check("mid_rst_ready",  32'(cfg_ready), 32'h0);
        repeat (2) @(posedge refclk);
        @(negedge refclk);
        rst_n = 1'b1;

        // Request held through LOCKING: ch3 divide by 10
        send(3'd3, 24'd10);
        at_edge(15); check("hold_ready_15", 32'(cfg_ready), 32'h0);
        at_edge(16); check("hold_lock_16", 32'(locked), 32'h1);
        check("hold_ready_16", 32'(cfg_ready), 32'h1);
        at_edge(17);
        cfg_valid = 1'b0;
        check("hold_ready_17", 32'(cfg_ready), 32'h0);
        check("hold_lock_17", 32'(locked), 32'h0);
        at_edge(27); check("ch3_tick_27", 32'(outclk_tick[3]), 32'h0);
        at_edge(28); check("ch3_tick_28", 32'(outclk_tick[3]), 32'h1);
        check("ch3_clk_28", 32'(outclk[3]), 32'h1);
        at_edge(33); check("ch3_clk_33", 32'(outclk[3]), 32'h0);
        check("hold_lock_33", 32'(locked), 32'h0);
        at_edge(34); check("hold_lock_34", 32'(locked), 32'h1);
        check("hold_err_34", 32'(cfg_err), 32'h0);
        at_edge(49 + PA); check("def_tick_pre", 32'(outclk_tick[2:0]), 32'h0);
        at_edge(50 + PA); check("def_tick", 32'(outclk_tick[2:0]), 32'h7);
        check("def_ch1_clk", 32'(outclk[1]), 32'h1);

`ifdef MY_CLKDIV_PHASE_ALIGN_EN
        // ch0 = 4, ch1 = 6: rising edges coincide every 12 cycles
        at_edge(70);
        send(3'd0, 24'd4);
        at_edge(71);
        cfg_valid = 1'b0;
        at_edge(88); check("pa_lock_88", 32'(locked), 32'h1);
        send(3'd1, 24'd6);
        at_edge(89);
        cfg_valid = 1'b0;
        at_edge(94);  check("pa_tick_94", 32'(outclk_tick[1:0]), 32'h1);
        at_edge(96);  check("pa_tick_96", 32'(outclk_tick[1:0]), 32'h2);
        at_edge(101); check("pa_clk_101", 32'(outclk[1:0]), 32'h0);
        at_edge(102); check("pa_clk_102", 32'(outclk[1:0]), 32'h3);
        check("pa_tick_102", 32'(outclk_tick[1:0]), 32'h3);
        at_edge(114); check("pa_tick_114", 32'(outclk_tick[1:0]), 32'h3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/my_clkdiv_multi.md
Name: my_clkdiv_multi

Overview:
- Parametrised, fully digital multi-channel clock generator. Successor to the single-output fixed-frequency PLL wrapper.
- Derives NUM_CH runtime-programmable divided clocks plus single-cycle clock-enable pulses from refclk.
- Has a lock indicator and a valid/ready reconfiguration port.
- Sits between the board reference clock and game logic (display scan, timers, debouncers). Downstream logic runs on refclk and uses the tick outputs as enables.

Parameters:
- NUM_CH, 4, number of output channels (1..8).
- CNT_W, 24, divisor and counter width in bits.
- DIV_DEFAULT, 50, reset divisor for every channel (must be >= 2). 100 MHz / 50 = 2 MHz.
- LOCK_CYCLES, 16, refclk cycles from reset release or reconfiguration until locked asserts (>= 1).

Ports:
- refclk  in  1  reference clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous active-low reset. Deassertion is synchronised externally.
- cfg_valid  in  1  reconfiguration request.
- cfg_ready  out  1  block accepts a request this cycle.
- cfg_ch  in  3  target channel index.
- cfg_div  in  CNT_W  new divisor N.
- cfg_err  out  1  one-cycle pulse when an accepted request is illegal.
- outclk  out  NUM_CH  divided square clocks, registered.
- outclk_tick  out  NUM_CH  one-cycle enable pulse per output period, registered.
- locked  out  1  all channels are stable at their programmed divisors.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All divisors = DIV_DEFAULT; all counters = 0.
  - outclk = 0, outclk_tick = 0, locked = 0, cfg_ready = 0, cfg_err = 0.
  - FSM enters LOCKING with lock counter = 0.
- Channel counter (per channel, divisor N):
  - Counts 0..N-1, then wraps to 0.
  - outclk_tick = 1 in the cycle after the counter equals N-1, so the tick coincides with count 0.
  - outclk = 1 while registered count < (N>>1), else 0.
  - Period is exactly N refclk cycles. N=3 gives 1 high, 2 low.
  - First rising outclk and first tick appear N cycles after the counter restarts.
  - Counters run in every FSM state.
- FSM states:
  - LOCKING: lock counter increments each cycle. At LOCK_CYCLES-1, move to LOCKED. locked = 0, cfg_ready = 0.
  - LOCKED: locked = 1, cfg_ready = 1.
    - Handshake completes on cfg_valid && cfg_ready.
    - Legal request (cfg_ch < NUM_CH and cfg_div >= 2): capture it and move to RECONF.
    - Illegal request: pulse cfg_err on the next cycle, no state change, remain LOCKED.
  - RECONF (exactly 1 cycle): write the captured divisor and force the target counter to 0. outclk and tick of that channel are 0 this cycle. Then LOCKING with lock counter cleared.
  - locked drops in the cycle after acceptance and stays 0 for LOCK_CYCLES+1 cycles.
- Exactly LOCK_CYCLES cycles after rst_n rises, locked = 1.
- cfg_ready is low outside LOCKED. A request held during LOCKING is accepted once LOCKED is reached.
- Divisor wider than CNT_W cannot occur (port width). N = 2^CNT_W-1 is legal.
- Reset mid-RECONF or mid-LOCKING: everything returns to reset values; pending configuration is discarded.

Optional Feature:
- Macro MY_CLKDIV_PHASE_ALIGN_EN.
- Defined: RECONF forces every channel counter to 0, not only the target. All channels restart phase-aligned, with rising edges coincident at common multiples.
- Undefined: only the target channel restarts; other channels continue undisturbed.

Decomposition:
- Package my_clkdiv_pkg holds:
  - FSM state enum: LOCKING, LOCKED, RECONF.
  - CH_IDX_W constant = 3.
  - A function checking divisor legality.
- Sub-module my_clkdiv_chan: one counter, divisor register, outclk/tick generation.
  - Inputs: restart, load, div.
  - Instantiated NUM_CH times via generate.
- Top level holds the FSM, lock counter and cfg handshake.

Test Plan:
- Reset release with defaults (N=50): locked rises on cycle 16; each outclk has a period of 50 cycles, high for 25; tick every 50 cycles.
- In LOCKED, write ch1 div=3: cfg_ready drops the next cycle and locked is 0 for 17 cycles. ch1 then has period 3 (1 high, 2 low). Other channels are undisturbed when the macro is undefined.
- Illegal requests: div=1 on ch0, then cfg_ch=5 with NUM_CH=4. Each gives one cfg_err pulse; divisors are unchanged and locked stays 1.
- cfg_valid held during LOCKING: accepted on the first LOCKED cycle, with no double acceptance.
- Assert rst_n=0 during RECONF: outputs clear immediately; after release, divisors are back to 50.
- With MY_CLKDIV_PHASE_ALIGN_EN: set ch0=4 and ch1=6. After the reconfiguration, rising outclk edges of ch0 and ch1 coincide every 12 cycles.
